// File: rtl/switch_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : switch_input_buffer
// Purpose  : Per-ingress-port flit buffer acting as the requester side of the
//            switch allocator. Flits are queued in a FIFO. The destination is
//            decoded from each head flit, and one allocation request is issued
//            per packet (retried on failure). Once granted, the buffer holds
//            `valid` and streams flits through the crossbar until the tail
//            leaves. It then drops `valid` for one cycle so the allocator
//            releases the output.
// Ports    : clk, n_rst             clock, asynchronous active-low reset
//            wr_en/wr_flit/wr_head/wr_tail/wr_vc   upstream flit write
//            full, credit_return   FIFO status, one pulse per dequeued flit
//            overflow, proto_err   sticky error flags
//            req_valid/req_egress_port/req_vc      SA request
//            resp_valid/resp_failed                SA response
//            valid                 allocation held (low = deallocate)
//            grant, rd_ready       crossbar routing / downstream ready
//            rd_valid, rd_flit     flit presented to crossbar
// Revision : 1.0  initial release
// ============================================================================
module switch_input_buffer #(
  parameter int DEPTH        = 8,
  parameter int FLIT_WIDTH   = 32,
  parameter int NUM_OUTPORTS = 4,
  parameter int NUM_VCS      = 2,
  parameter int DEST_LSB     = 24,
  localparam int PORT_W = $clog2(NUM_OUTPORTS) + ((NUM_OUTPORTS == 1) ? 1 : 0),
  localparam int VC_W   = $clog2(NUM_VCS) + ((NUM_VCS == 1) ? 1 : 0)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_en,
  input  logic [FLIT_WIDTH-1:0] wr_flit,
  input  logic                  wr_head,
  input  logic                  wr_tail,
  input  logic [VC_W-1:0]       wr_vc,
  output logic                  full,
  output logic                  credit_return,
  output logic                  overflow,
  output logic                  proto_err,
  output logic                  req_valid,
  output logic [PORT_W-1:0]     req_egress_port,
  output logic [VC_W-1:0]       req_vc,
  input  logic                  resp_valid,
  input  logic                  resp_failed,
  output logic                  valid,
  input  logic                  grant,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [FLIT_WIDTH-1:0] rd_flit
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          ENTRY_W    = FLIT_WIDTH + 2 + VC_W;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_GRANTED = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Entry layout: {flit, head, tail, vc}
  logic [ENTRY_W-1:0]    entry_q [DEPTH];
  logic [ENTRY_W-1:0]    entry_d [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [2:0]            state_q, state_d;
  logic [PORT_W-1:0]     egress_q, egress_d;
  logic [VC_W-1:0]       vc_q, vc_d;
  logic                  overflow_q, overflow_d;
  logic                  proto_err_q, proto_err_d;

  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    front;
  logic [FLIT_WIDTH-1:0] front_flit;
  logic                  front_head;
  logic                  front_tail;
  logic [VC_W-1:0]       front_vc;
  logic [AW:0]           count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  wr_fire;
  logic                  out_valid;
  logic                  deq_discard;
  logic                  deq;

  assign wr_entry = {wr_flit, wr_head, wr_tail, wr_vc};
  assign front    = entry_q[rd_ptr_q[AW-1:0]];
  assign {front_flit, front_head, front_tail, front_vc} = front;

  // Extra pointer MSB separates full (count==DEPTH) from empty (count==0).
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  // Fullness is taken from the registered pointers, so a read in the same
  // cycle never makes room for a write.
  assign wr_fire = wr_en && !fifo_full;

  assign out_valid   = (state_q == ST_GRANTED) && grant && !fifo_empty;
  // A non-head flit at the front while idle has no owning packet: drop it.
  assign deq_discard = (state_q == ST_IDLE) && !fifo_empty && !front_head;
  assign deq         = (out_valid && rd_ready) || deq_discard;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_d[i] = entry_q[i];
    if (wr_fire) entry_d[wr_ptr_q[AW-1:0]] = wr_entry;
  end

  always_comb begin
    wr_ptr_d    = wr_fire ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = deq ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    state_d     = state_q;
    egress_d    = egress_q;
    vc_d        = vc_q;
    overflow_d  = overflow_q || (wr_en && fifo_full);
    proto_err_d = proto_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (front_head) begin
            egress_d = front_flit[DEST_LSB +: PORT_W];
            vc_d     = front_vc;
            state_d  = ST_REQ;
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (resp_valid) state_d = resp_failed ? ST_REQ : ST_GRANTED;
      end
      ST_GRANTED: begin
        if (out_valid && rd_ready && front_tail) state_d = ST_RELEASE;
      end
      // One cycle with valid low lets the allocator see the release before
      // the next head is considered.
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      egress_q    <= '0;
      vc_q        <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      egress_q    <= egress_d;
      vc_q        <= vc_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign full            = fifo_full;
  assign credit_return   = deq;
  assign overflow        = overflow_q;
  assign proto_err       = proto_err_q;
  assign req_valid       = (state_q == ST_REQ);
  assign req_egress_port = egress_q;
  assign req_vc          = vc_q;
  assign valid           = (state_q == ST_GRANTED);
  assign rd_valid        = out_valid;
  assign rd_flit         = front_flit;

endmodule
`default_nettype wire

// File: tb/tb_switch_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_input_buffer
// Purpose  : Directed self-checking bench for switch_input_buffer.
//            Inputs change 1 ns after the rising edge. Outputs are checked
//            1 ns after that.
// Revision : 1.0  initial release
// ============================================================================
module tb_switch_input_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        wr_en;
  logic [31:0] wr_flit;
  logic        wr_head;
  logic        wr_tail;
  logic [0:0]  wr_vc;
  logic        full;
  logic        credit_return;
  logic        overflow;
  logic        proto_err;
  logic        req_valid;
  logic [1:0]  req_egress_port;
  logic [0:0]  req_vc;
  logic        resp_valid;
  logic        resp_failed;
  logic        valid;
  logic        grant;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_flit;

  int n_cmp = 0;
  int n_err = 0;

  // {req_valid, valid, rd_valid, credit_return}
  wire [3:0] ctl = {req_valid, valid, rd_valid, credit_return};

  switch_input_buffer dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .wr_en           (wr_en),
    .wr_flit         (wr_flit),
    .wr_head         (wr_head),
    .wr_tail         (wr_tail),
    .wr_vc           (wr_vc),
    .full            (full),
    .credit_return   (credit_return),
    .overflow        (overflow),
    .proto_err       (proto_err),
    .req_valid       (req_valid),
    .req_egress_port (req_egress_port),
    .req_vc          (req_vc),
    .resp_valid      (resp_valid),
    .resp_failed     (resp_failed),
    .valid           (valid),
    .grant           (grant),
    .rd_ready        (rd_ready),
    .rd_valid        (rd_valid),
    .rd_flit         (rd_flit)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_wr(input logic en, input logic [31:0] f, input logic h,
                        input logic t, input logic v);
    wr_en   = en;
    wr_flit = f;
    wr_head = h;
    wr_tail = t;
    wr_vc   = v;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    drv_wr(0, 32'h0, 0, 0, 0);
    resp_valid = 0; resp_failed = 0; grant = 0; rd_ready = 0;
    #12;
    n_cmp++;
    if ({ctl, full, overflow, proto_err, req_egress_port, req_vc, rd_flit} !== 42'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got ctl=%b full=%b ovf=%b perr=%b port=%0d vc=%0d flit=%h want all 0",
               ctl, full, overflow, proto_err, req_egress_port, req_vc, rd_flit);
    end
    @(negedge clk);
    n_rst = 1'b1;
    cyc();
    n_cmp++;
    if (ctl !== 4'b0000) begin
      n_err++; $display("FAIL reset_idle: got ctl=%b want 0000", ctl);
    end
  endtask

  task automatic test_basic();
    grant = 1; rd_ready = 1;
    drv_wr(1, 32'h0200_00A1, 1, 0, 1); cyc();
    drv_wr(1, 32'h0000_00A2, 0, 0, 1); #1;
    n_cmp++;
    if (ctl !== 4'b0000) begin n_err++; $display("FAIL basic_eval: got ctl=%b want 0000", ctl); end
    cyc(); drv_wr(1, 32'h0000_00A3, 0, 1, 1); #1;
    n_cmp++;
    if ({ctl, req_egress_port, req_vc} !== {4'b1000, 2'd2, 1'b1}) begin
      n_err++; $display("FAIL basic_req: got ctl=%b port=%0d vc=%0d want 1000/2/1", ctl, req_egress_port, req_vc);
    end
    cyc(); drv_wr(0, 32'h0, 0, 0, 0); resp_valid = 1; resp_failed = 0; #1;
    n_cmp++;
    if (ctl !== 4'b0000) begin n_err++; $display("FAIL basic_wait: got ctl=%b want 0000", ctl); end
    cyc(); resp_valid = 0; #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0200_00A1}) begin
      n_err++; $display("FAIL basic_rd0: got ctl=%b flit=%h want 0111/020000a1", ctl, rd_flit);
    end
    cyc(); #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0000_00A2}) begin
      n_err++; $display("FAIL basic_rd1: got ctl=%b flit=%h want 0111/000000a2", ctl, rd_flit);
    end
    cyc(); #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0000_00A3}) begin
      n_err++; $display("FAIL basic_rd2: got ctl=%b flit=%h want 0111/000000a3", ctl, rd_flit);
    end
    cyc(); #1;
    n_cmp++;
    if (ctl !== 4'b0000) begin n_err++; $display("FAIL basic_release: got ctl=%b want 0000", ctl); end
    cyc(); #1;
    n_cmp++;
    if ({ctl, full} !== 5'b00000) begin n_err++; $display("FAIL basic_idle: got ctl=%b full=%b want 0000/0", ctl, full); end
  endtask

  task automatic test_retry();
    drv_wr(1, 32'h0200_00B1, 1, 0, 1); cyc();
    drv_wr(1, 32'h0000_00B2, 0, 0, 1); cyc();
    drv_wr(1, 32'h0000_00B3, 0, 1, 1); #1;
    n_cmp++;
    if ({ctl, req_egress_port, req_vc} !== {4'b1000, 2'd2, 1'b1}) begin
      n_err++; $display("FAIL retry_req1: got ctl=%b port=%0d vc=%0d want 1000/2/1", ctl, req_egress_port, req_vc);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(); drv_wr(0, 32'h0, 0, 0, 0); resp_valid = 1; resp_failed = 1; #1;
      n_cmp++;
      if (ctl !== 4'b0000) begin n_err++; $display("FAIL retry_wait%0d: got ctl=%b want 0000", k, ctl); end
      cyc(); resp_valid = 0; resp_failed = 0; #1;
      n_cmp++;
      if ({ctl, req_egress_port, req_vc} !== {4'b1000, 2'd2, 1'b1}) begin
        n_err++; $display("FAIL retry_req%0d: got ctl=%b port=%0d vc=%0d want 1000/2/1", k + 2, ctl, req_egress_port, req_vc);
      end
    end
    cyc(); resp_valid = 1; #1;
    cyc(); resp_valid = 0; #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0200_00B1}) begin
      n_err++; $display("FAIL retry_rd0: got ctl=%b flit=%h want 0111/020000b1", ctl, rd_flit);
    end
    cyc(); cyc(); #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0000_00B3}) begin
      n_err++; $display("FAIL retry_rd2: got ctl=%b flit=%h want 0111/000000b3", ctl, rd_flit);
    end
    cyc(); cyc(); #1;
  endtask

  task automatic test_grant_hold();
    drv_wr(1, 32'h0100_00C1, 1, 0, 0); cyc();
    drv_wr(1, 32'h0000_00C2, 0, 0, 0); cyc();
    drv_wr(1, 32'h0000_00C3, 0, 1, 0); #1;
    n_cmp++;
    if ({ctl, req_egress_port, req_vc} !== {4'b1000, 2'd1, 1'b0}) begin
      n_err++; $display("FAIL hold_req: got ctl=%b port=%0d vc=%0d want 1000/1/0", ctl, req_egress_port, req_vc);
    end
    cyc(); drv_wr(0, 32'h0, 0, 0, 0); resp_valid = 1;
    cyc(); resp_valid = 0; #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0100_00C1}) begin
      n_err++; $display("FAIL hold_rd0: got ctl=%b flit=%h want 0111/010000c1", ctl, rd_flit);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(); grant = 0; #1;
      n_cmp++;
      if ({ctl, rd_flit} !== {4'b0100, 32'h0000_00C2}) begin
        n_err++; $display("FAIL hold_low%0d: got ctl=%b flit=%h want 0100/000000c2", k, ctl, rd_flit);
      end
    end
    cyc(); grant = 1; #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0000_00C2}) begin
      n_err++; $display("FAIL hold_resume: got ctl=%b flit=%h want 0111/000000c2", ctl, rd_flit);
    end
    cyc(); #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0000_00C3}) begin
      n_err++; $display("FAIL hold_tail: got ctl=%b flit=%h want 0111/000000c3", ctl, rd_flit);
    end
    cyc(); cyc(); #1;
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    grant = 0; rd_ready = 0;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 0) ? 32'h0300_0010 : 32'h0000_0010 + i;
      drv_wr(1, exp, (i == 0), (i == 7), 0);
      cyc();
    end
    drv_wr(1, 32'hDEAD_BEEF, 0, 0, 0); #1;
    n_cmp++;
    if ({full, overflow} !== 2'b10) begin
      n_err++; $display("FAIL ovf_full: got full=%b ovf=%b want 1/0", full, overflow);
    end
    cyc(); drv_wr(0, 32'h0, 0, 0, 0); resp_valid = 1; #1;
    n_cmp++;
    if ({full, overflow} !== 2'b11) begin
      n_err++; $display("FAIL ovf_set: got full=%b ovf=%b want 1/1", full, overflow);
    end
    cyc(); resp_valid = 0; grant = 1; rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 0) ? 32'h0300_0010 : 32'h0000_0010 + i;
      #1;
      n_cmp++;
      if ({rd_valid, credit_return, full, rd_flit} !== {2'b11, (i == 0), exp}) begin
        n_err++; $display("FAIL ovf_drain%0d: got rv=%b cr=%b full=%b flit=%h want 1/1/%0d/%h",
                          i, rd_valid, credit_return, full, rd_flit, (i == 0), exp);
      end
      cyc();
    end
    #1;
    n_cmp++;
    if ({ctl, full, overflow} !== 6'b000001) begin
      n_err++; $display("FAIL ovf_release: got ctl=%b full=%b ovf=%b want 0000/0/1", ctl, full, overflow);
    end
    cyc(); cyc(); #1;
    n_cmp++;
    if (ctl !== 4'b0000) begin n_err++; $display("FAIL ovf_empty: got ctl=%b want 0000", ctl); end
  endtask

  task automatic test_proto_err();
    drv_wr(1, 32'h0000_00E1, 0, 0, 0); cyc();
    drv_wr(0, 32'h0, 0, 0, 0); #1;
    n_cmp++;
    if ({ctl, proto_err} !== 5'b00010) begin
      n_err++; $display("FAIL perr_discard: got ctl=%b perr=%b want 0001/0", ctl, proto_err);
    end
    cyc(); #1;
    n_cmp++;
    if ({ctl, proto_err} !== 5'b00001) begin
      n_err++; $display("FAIL perr_flag: got ctl=%b perr=%b want 0000/1", ctl, proto_err);
    end
    cyc(); #1;
    n_cmp++;
    if (ctl !== 4'b0000) begin n_err++; $display("FAIL perr_noreq: got ctl=%b want 0000", ctl); end
  endtask

  task automatic test_back_to_back();
    grant = 1; rd_ready = 1;
    drv_wr(1, 32'h0000_00A0, 1, 1, 0); cyc();
    drv_wr(1, 32'h0300_00B0, 1, 1, 1); cyc();
    drv_wr(0, 32'h0, 0, 0, 0); #1;
    n_cmp++;
    if ({ctl, req_egress_port, req_vc} !== {4'b1000, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL b2b_req0: got ctl=%b port=%0d vc=%0d want 1000/0/0", ctl, req_egress_port, req_vc);
    end
    cyc(); resp_valid = 1;
    cyc(); resp_valid = 0; #1;
    n_cmp++;
    if ({ctl, rd_flit} !== {4'b0111, 32'h0000_00A0}) begin
      n_err++; $display("FAIL b2b_rd0: got ctl=%b flit=%h want 0111/000000a0", ctl, rd_flit);
    end
    cyc(); #1;
    n_cmp++;
    if (ctl !== 4'b0000) begin n_err++; $display("FAIL b2b_gap: got ctl=%b want 0000", ctl); end
    cyc(); cyc(); #1;
    n_cmp++;
    if ({ctl, req_egress_port, req_vc} !== {4'b1000, 2'd3, 1'b1}) begin
      n_err++; $display("FAIL b2b_req1: got ctl=%b port=%0d vc=%0d want 1000/3/1", ctl, req_egress_port, req_vc);
    end
    cyc(); resp_valid = 1;
    cyc(); resp_valid = 0; rd_ready = 0; #1;
    n_cmp++;
    if ({ctl, rd_flit, overflow, proto_err} !== {4'b0110, 32'h0300_00B0, 2'b11}) begin
      n_err++; $display("FAIL b2b_hold: got ctl=%b flit=%h ovf=%b perr=%b want 0110/030000b0/1/1",
                        ctl, rd_flit, overflow, proto_err);
    end
    #2 n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({ctl, full, overflow, proto_err, req_egress_port, req_vc, rd_flit} !== 42'h0) begin
      n_err++; $display("FAIL b2b_async_rst: got ctl=%b full=%b ovf=%b perr=%b port=%0d vc=%0d flit=%h want all 0",
                        ctl, full, overflow, proto_err, req_egress_port, req_vc, rd_flit);
    end
    @(negedge clk);
    n_rst = 1'b1;
    rd_ready = 1;
    cyc(); cyc(); cyc(); #1;
    n_cmp++;
    if (ctl !== 4'b0000) begin n_err++; $display("FAIL b2b_post_rst: got ctl=%b want 0000", ctl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_grant_hold();
    test_overflow();
    test_proto_err();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
